// File: rtl/tow_scorer.sv
// Tug-of-war game controller: consumes latched push flags, moves the rope marker,
// re-arms the latch with a clr hold window, and latches the winner until reset.
module tow_scorer #(
    parameter int unsigned HALF        = 3,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic                right_i,
    input  logic                tie_i,
    output logic                clr_o,
    output logic [2*HALF:0]     leds_o,
    output logic                ready_o,
    output logic                win_l_o,
    output logic                win_r_o,
    output logic [CNT_W-1:0]    moves_o
);

    localparam int unsigned LED_W = 2 * HALF + 1;
    localparam int unsigned POS_W = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam int unsigned HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(2 * HALF);
    localparam logic [POS_W-1:0] POS_CTR   = POS_W'(HALF);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_CLEAR = 2'd1,
        ST_WIN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [HC_W-1:0]    hold_q, hold_d;
    logic               clr_q, clr_d;
    logic               win_l_q, win_l_d;
    logic               win_r_q, win_r_d;
    logic [CNT_W-1:0]   moves_q, moves_d;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        clr_d   = clr_q;
        win_l_d = win_l_q;
        win_r_d = win_r_q;
        moves_d = moves_q;

        case (state_q)
            ST_READY: begin
                if (push_i) begin
                    // tie outranks right; a left move is the fall-through case
                    if (tie_i) begin
                        pos_d = pos_q;
                    end else if (right_i) begin
                        pos_d = pos_q + POS_W'(1);
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                    if (moves_q != '1) begin
                        moves_d = moves_q + CNT_W'(1);
                    end
                    clr_d  = 1'b1;
                    hold_d = '0;
                    if (pos_d == POS_MAX) begin
                        state_d = ST_WIN;
                        win_r_d = 1'b1;
                    end else if (pos_d == '0) begin
                        state_d = ST_WIN;
                        win_l_d = 1'b1;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_READY;
                    clr_d   = 1'b0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            ST_WIN: begin
                clr_d = 1'b1;
            end
            default: begin
                state_d = ST_READY;
                clr_d   = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_READY;
            pos_q   <= POS_CTR;
            hold_q  <= '0;
            clr_q   <= 1'b0;
            win_l_q <= 1'b0;
            win_r_q <= 1'b0;
            moves_q <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
            clr_q   <= clr_d;
            win_l_q <= win_l_d;
            win_r_q <= win_r_d;
            moves_q <= moves_d;
        end
    end

    assign leds_o  = LED_W'(1) << pos_q;
    assign ready_o = (state_q == ST_READY);
    assign clr_o   = clr_q;
    assign win_l_o = win_l_q;
    assign win_r_o = win_r_q;
    assign moves_o = moves_q;

endmodule

// File: tb/tb_tow_scorer.sv
// Scoreboard bench for tow_scorer: a per-edge game model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_tow_scorer;

    localparam int HALF  = 3;
    localparam int HOLD  = 4;
    localparam int CNT_W = 8;
    localparam int W     = 2 * HALF + 1;

    logic             clk = 1'b0;
    logic             rst, push, right, tie;
    logic             clr, ready, win_l, win_r;
    logic [W-1:0]     leds;
    logic [CNT_W-1:0] moves;

    tow_scorer #(.HALF(HALF), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .right_i (right),
        .tie_i   (tie),
        .clr_o   (clr),
        .leds_o  (leds),
        .ready_o (ready),
        .win_l_o (win_l),
        .win_r_o (win_r),
        .moves_o (moves)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             clr;
        logic [W-1:0]     leds;
        logic             ready;
        logic             wl;
        logic             wr;
        logic [CNT_W-1:0] moves;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Game model: position as a plain integer, remaining clr cycles as a countdown.
    int m_pos = HALF, m_busy = 0, m_moves = 0;
    bit m_won = 0, m_wl = 0, m_wr = 0, m_started = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_started && !m_won && (m_busy == 0);
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pos = HALF; m_busy = 0; m_moves = 0;
                m_won = 0; m_wl = 0; m_wr = 0; m_started = 1;
            end else if (!m_started || m_won) begin
                // nothing moves before first reset or after a win
            end else if (m_busy > 0) begin
                m_busy--;
            end else if (push) begin
                if (tie)        m_pos = m_pos;
                else if (right) m_pos = m_pos + 1;
                else            m_pos = m_pos - 1;
                if (m_moves < (1 << CNT_W) - 1) m_moves++;
                if (m_pos == 2 * HALF) begin m_won = 1; m_wr = 1; end
                else if (m_pos == 0)   begin m_won = 1; m_wl = 1; end
                else                   m_busy = HOLD;
            end
            if (m_started) begin
                e.clr   = m_won || (m_busy > 0);
                e.leds  = '0;
                e.leds[m_pos] = 1'b1;
                e.ready = !m_won && (m_busy == 0);
                e.wl    = m_wl;
                e.wr    = m_wr;
                e.moves = CNT_W'(m_moves);
                q.push_back(e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("clr",   int'(clr),   int'(e.clr));
                chk("leds",  int'(leds),  int'(e.leds));
                chk("ready", int'(ready), int'(e.ready));
                chk("win_l", int'(win_l), int'(e.wl));
                chk("win_r", int'(win_r), int'(e.wr));
                chk("moves", int'(moves), int'(e.moves));
                chk("win_excl", int'(win_l & win_r), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; push = 1'b0; right = 1'b0; tie = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic push_when_ready(input logic r, input logic t);
        int n = 0;
        while (!m_ready() && n < 20) begin
            tick();
            n++;
        end
        if (!m_ready()) chk("ready_timeout", 0, 1);
        push = 1'b1; right = r; tie = t;
        tick();
        push = 1'b0; right = 1'b0; tie = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; right = 1'b0; tie = 1'b0;

        // Reset values
        do_reset(2);
        @(negedge clk);
        chk("rst_leds", int'(leds), 'b0001000);
        chk("rst_ready", int'(ready), 1);
        chk("rst_moves", int'(moves), 0);

        // Single right push, clr window, back to ready
        push_when_ready(1'b1, 1'b0);
        @(negedge clk);
        chk("right_leds", int'(leds), 'b0010000);
        chk("right_clr", int'(clr), 1);
        repeat (4) tick();
        @(negedge clk);
        chk("right_ready", int'(ready), 1);
        chk("right_moves", int'(moves), 1);

        // Tie with right also set
        do_reset(1);
        push_when_ready(1'b1, 1'b1);
        @(negedge clk);
        chk("tie_leds", int'(leds), 'b0001000);
        chk("tie_moves", int'(moves), 1);

        // Left win, then absorbing
        do_reset(1);
        repeat (3) push_when_ready(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            push = 1'b1; right = 1'($urandom_range(0, 1)); tie = 1'($urandom_range(0, 1));
            tick();
        end
        push = 1'b0; right = 1'b0; tie = 1'b0;
        @(negedge clk);
        chk("winl_flag", int'(win_l), 1);
        chk("winl_leds", int'(leds), 'b0000001);
        chk("winl_moves", int'(moves), 3);

        // Push held high: one move per 5-cycle round
        do_reset(1);
        push = 1'b1; tie = 1'b1; right = 1'b0;
        repeat (25) tick();
        push = 1'b0; tie = 1'b0;
        @(negedge clk);
        chk("held_moves", int'(moves), 5);

        // Reset in 2nd CLEAR cycle, then right win
        do_reset(1);
        push_when_ready(1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_leds", int'(leds), 'b0001000);
        chk("midrst_clr", int'(clr), 0);
        chk("midrst_moves", int'(moves), 0);
        repeat (3) push_when_ready(1'b1, 1'b0);
        @(negedge clk);
        chk("winr_flag", int'(win_r), 1);
        chk("winr_leds", int'(leds), 'b1000000);

        // Random traffic with occasional resets and inconsistent flags
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            push  = 1'($urandom_range(0, 1));
            right = 1'($urandom_range(0, 1));
            tie   = ($urandom_range(0, 5) == 0);
            tick();
        end
        rst = 1'b0; push = 1'b0; right = 1'b0; tie = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
